mole_game_fsm: RTL and testbench



---
 rtl/mole_game_fsm.sv | 197 +++++++++++++++++++
 tb/tb_mole_game_fsm.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_fsm.sv
// Whack-a-mole round controller: sequences each round, picks hole locations
// from an LFSR, handshakes ascend/descend with the display, scores hits and
// tracks lives. All outputs are registered.
module mole_game_fsm #(
   parameter int          LIVES_INIT   = 3,
   parameter int          START_DELAY  = 65_000_000,
   parameter int          MOLE_TIMEOUT = 97_500_000,
   parameter int          SOUND_CYCLES = 32_500_000,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic       vclock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] pad_hit,
   input  logic       popup_done,
   output logic [3:0] state,
   output logic [2:0] mole_location,
   output logic [3:0] score_tens,
   output logic [3:0] score_ones,
   output logic [1:0] lives,
   output logic       hit_snd,
   output logic       miss_snd
);

   // Shared state encoding with the display mux.
   localparam logic [3:0] S_IDLE               = 4'd0;
   localparam logic [3:0] S_GAME_START_DELAY   = 4'd1;
   localparam logic [3:0] S_GAME_ONGOING       = 4'd2;
   localparam logic [3:0] S_REQUEST_MOLE       = 4'd3;
   localparam logic [3:0] S_MOLE_COUNTDOWN     = 4'd4;
   localparam logic [3:0] S_MOLE_MISSED        = 4'd5;
   localparam logic [3:0] S_MOLE_WHACKED       = 4'd6;
   localparam logic [3:0] S_GAME_OVER          = 4'd8;
   localparam logic [3:0] S_MOLE_MISSED_SOUND  = 4'd9;
   localparam logic [3:0] S_MOLE_WHACKED_SOUND = 4'd10;
   localparam logic [3:0] S_MOLE_ASCENDING     = 4'd13;
   localparam logic [3:0] S_HAPPY_MOLE_DESC    = 4'd14;
   localparam logic [3:0] S_DEAD_MOLE_DESC     = 4'd15;

   // A timer loaded with N-1 keeps the FSM in a state for N cycles.
   localparam logic [26:0] START_LOAD = 27'(START_DELAY - 1);
   localparam logic [26:0] MOLE_LOAD  = 27'(MOLE_TIMEOUT - 1);
   localparam logic [26:0] SOUND_LOAD = 27'(SOUND_CYCLES - 1);
   localparam logic [1:0]  LIVES_LOAD = 2'(LIVES_INIT);

   logic [3:0]  state_q, state_d;
   logic [2:0]  loc_q, loc_d;
   logic [3:0]  tens_q, tens_d;
   logic [3:0]  ones_q, ones_d;
   logic [1:0]  lives_q, lives_d;
   logic        hit_q, hit_d;
   logic        miss_q, miss_d;
   logic [26:0] timer_q, timer_d;
   logic        start_q;
   logic        first_q;        // high on the first cycle of a newly entered state
   logic [15:0] lfsr_q, lfsr_d;
   logic        reset_prev_q;

   logic        start_edge;
   logic        popup_ok;
   logic        mole_hit;
   logic        timer_zero;
   logic [2:0]  cand;

   assign start_edge = start & ~start_q;
   // The display flag lags by one registered cycle, so ignore it on entry.
   assign popup_ok   = popup_done & ~first_q;
   assign mole_hit   = pad_hit[loc_q];
   assign timer_zero = (timer_q == 27'd0);
   // Never repeat the previous hole: bump a colliding candidate by one.
   assign cand       = (lfsr_q[2:0] == loc_q) ? lfsr_q[2:0] + 3'd1 : lfsr_q[2:0];
   // Fibonacci LFSR, taps 16,14,13,11.
   assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // Next-state, timer, score and lives logic.
   always_comb begin
      state_d = state_q;
      loc_d   = loc_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      lives_d = lives_q;
      timer_d = timer_q;
      case (state_q)
         S_IDLE, S_GAME_OVER: begin
            if (start_edge) begin
               tens_d  = 4'd0;
               ones_d  = 4'd0;
               lives_d = LIVES_LOAD;
               timer_d = START_LOAD;
               state_d = S_GAME_START_DELAY;
            end
         end
         S_GAME_START_DELAY: begin
            if (timer_zero) state_d = S_GAME_ONGOING;
            else            timer_d = timer_q - 27'd1;
         end
         S_GAME_ONGOING: begin
            if (lives_q == 2'd0) begin
               state_d = S_GAME_OVER;
            end else begin
               loc_d   = cand;
               state_d = S_REQUEST_MOLE;
            end
         end
         S_REQUEST_MOLE: state_d = S_MOLE_ASCENDING;
         S_MOLE_ASCENDING: begin
            if (mole_hit) begin
               state_d = S_MOLE_WHACKED;
            end else if (popup_ok) begin
               timer_d = MOLE_LOAD;
               state_d = S_MOLE_COUNTDOWN;
            end
         end
         S_MOLE_COUNTDOWN: begin
            if (mole_hit)        state_d = S_MOLE_WHACKED;
            else if (timer_zero) state_d = S_MOLE_MISSED;
            else                 timer_d = timer_q - 27'd1;
         end
         S_MOLE_WHACKED: begin
            // BCD increment saturating at 99.
            if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
               if (ones_q == 4'd9) begin
                  ones_d = 4'd0;
                  tens_d = tens_q + 4'd1;
               end else begin
                  ones_d = ones_q + 4'd1;
               end
            end
            timer_d = SOUND_LOAD;
            state_d = S_MOLE_WHACKED_SOUND;
         end
         S_MOLE_WHACKED_SOUND: begin
            if (timer_zero) state_d = S_DEAD_MOLE_DESC;
            else            timer_d = timer_q - 27'd1;
         end
         S_MOLE_MISSED: begin
            if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
            timer_d = SOUND_LOAD;
            state_d = S_MOLE_MISSED_SOUND;
         end
         S_MOLE_MISSED_SOUND: begin
            if (timer_zero) state_d = S_HAPPY_MOLE_DESC;
            else            timer_d = timer_q - 27'd1;
         end
         S_HAPPY_MOLE_DESC, S_DEAD_MOLE_DESC: begin
            if (popup_ok) state_d = S_GAME_ONGOING;
         end
         default: state_d = S_IDLE;  // illegal codes 7, 11, 12
      endcase
      // Sound pulses coincide exactly with the WHACKED / MISSED state cycle.
      hit_d  = (state_d == S_MOLE_WHACKED);
      miss_d = (state_d == S_MOLE_MISSED);
   end

   // Game state registers with synchronous reset.
   always_ff @(posedge vclock) begin
      if (reset) begin
         state_q <= S_IDLE;
         loc_q   <= 3'd0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         lives_q <= 2'd0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
         timer_q <= 27'd0;
         start_q <= 1'b1;   // a button held through reset must not start a game
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         loc_q   <= loc_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         lives_q <= lives_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         timer_q <= timer_d;
         start_q <= start;
         first_q <= (state_d != state_q);
      end
   end

   // LFSR: seeded on the first reset cycle, free-running otherwise (even in reset).
   always_ff @(posedge vclock) begin
      reset_prev_q <= reset;
      if (!reset || reset_prev_q) lfsr_q <= lfsr_d;
      else                        lfsr_q <= LFSR_SEED;
   end

   assign state         = state_q;
   assign mole_location = loc_q;
   assign score_tens    = tens_q;
   assign score_ones    = ones_q;
   assign lives         = lives_q;
   assign hit_snd       = hit_q;
   assign miss_snd      = miss_q;

endmodule

// File: tb/tb_mole_game_fsm.sv
// Directed bench for mole_game_fsm with short timing parameters.
module tb_mole_game_fsm;

   logic       vclock = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] pad_hit;
   logic       popup_done;
   logic [3:0] state;
   logic [2:0] mole_location;
   logic [3:0] score_tens;
   logic [3:0] score_ones;
   logic [1:0] lives;
   logic       hit_snd;
   logic       miss_snd;

   int checks = 0;
   int errors = 0;
   int prev_loc = -1;
   int loc_repeats = 0;

   mole_game_fsm #(
      .LIVES_INIT   (3),
      .START_DELAY  (10),
      .MOLE_TIMEOUT (50),
      .SOUND_CYCLES (4),
      .LFSR_SEED    (16'hACE1)
   ) dut (
      .vclock        (vclock),
      .reset         (reset),
      .start         (start),
      .pad_hit       (pad_hit),
      .popup_done    (popup_done),
      .state         (state),
      .mole_location (mole_location),
      .score_tens    (score_tens),
      .score_ones    (score_ones),
      .lives         (lives),
      .hit_snd       (hit_snd),
      .miss_snd      (miss_snd)
   );

   always #5 vclock = ~vclock;

   task automatic tick();
      @(posedge vclock);
      #1;
   endtask

   task automatic wait_for(input logic [3:0] s, input int max, output int n, output bit ok);
      n = 0;
      while (state !== s && n < max) begin
         tick();
         n++;
      end
      ok = (state === s);
   endtask

   task automatic note_location();
      if (prev_loc >= 0 && prev_loc == int'(mole_location)) loc_repeats++;
      prev_loc = int'(mole_location);
   endtask

   // From GAME_ONGOING: whack on the first ascending cycle, return to GAME_ONGOING.
   task automatic whack_round(output bit ok);
      int n;
      bit ok1;
      ok = 1'b1;
      tick();
      ok &= (state === 4'd3);
      note_location();
      tick();
      pad_hit = 8'd1 << mole_location;
      tick();
      pad_hit = 8'd0;
      ok &= (state === 4'd6);
      wait_for(4'd15, 20, n, ok1);
      ok &= ok1;
      popup_done = 1'b1;
      wait_for(4'd2, 5, n, ok1);
      ok &= ok1;
      popup_done = 1'b0;
   endtask

   // From GAME_ONGOING: let the mole time out, return to GAME_ONGOING.
   task automatic miss_round(output bit ok);
      int n;
      bit ok1;
      ok = 1'b1;
      tick();
      ok &= (state === 4'd3);
      note_location();
      tick();
      popup_done = 1'b1;
      tick();
      tick();
      popup_done = 1'b0;
      ok &= (state === 4'd4);
      wait_for(4'd5, 60, n, ok1);
      ok &= ok1;
      wait_for(4'd14, 10, n, ok1);
      ok &= ok1;
      popup_done = 1'b1;
      wait_for(4'd2, 5, n, ok1);
      ok &= ok1;
      popup_done = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; pad_hit = 8'd0; popup_done = 1'b0;
      repeat (3) tick();
      checks++;
      if (state !== 4'd0 || mole_location !== 3'd0 || lives !== 2'd0 ||
          score_tens !== 4'd0 || score_ones !== 4'd0 || hit_snd !== 1'b0 || miss_snd !== 1'b0) begin
         errors++;
         $display("FAIL reset_values state=%0d loc=%0d lives=%0d score=%0d%0d hit=%0b miss=%0b expected all zero",
                  state, mole_location, lives, score_tens, score_ones, hit_snd, miss_snd);
      end
      $display("reset: state=%0d lives=%0d", state, lives);
      reset = 1'b0;
      repeat (3) tick();
      checks++;
      if (state !== 4'd0) begin
         errors++;
         $display("FAIL start_held_through_reset state=%0d expected=0", state);
      end
      $display("start held after reset: state=%0d", state);
   endtask

   task automatic test_start_delay();
      int n;
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      checks++;
      if (state !== 4'd1 || lives !== 2'd3 || score_tens !== 4'd0 || score_ones !== 4'd0) begin
         errors++;
         $display("FAIL start_game state=%0d lives=%0d score=%0d%0d expected state=1 lives=3 score=00",
                  state, lives, score_tens, score_ones);
      end
      n = 0;
      while (state === 4'd1 && n < 30) begin
         tick();
         n++;
      end
      checks++;
      if (state !== 4'd2 || n != 10) begin
         errors++;
         $display("FAIL start_delay state=%0d cycles=%0d expected state=2 cycles=10", state, n);
      end
      $display("start delay: %0d cycles, state=%0d", n, state);
      start = 1'b0;
   endtask

   task automatic test_whack();
      int n;
      tick();
      checks++;
      if (state !== 4'd3) begin
         errors++;
         $display("FAIL whack_request state=%0d expected=3", state);
      end
      note_location();
      tick();
      checks++;
      if (state !== 4'd13) begin
         errors++;
         $display("FAIL whack_ascending state=%0d expected=13", state);
      end
      repeat (4) tick();
      popup_done = 1'b1;
      tick();
      popup_done = 1'b0;
      checks++;
      if (state !== 4'd4) begin
         errors++;
         $display("FAIL whack_countdown state=%0d expected=4", state);
      end
      repeat (2) tick();
      pad_hit = 8'd1 << mole_location;
      tick();
      pad_hit = 8'd0;
      checks++;
      if (state !== 4'd6 || hit_snd !== 1'b1 || miss_snd !== 1'b0) begin
         errors++;
         $display("FAIL whack_hit state=%0d hit=%0b miss=%0b expected state=6 hit=1 miss=0", state, hit_snd, miss_snd);
      end
      tick();
      checks++;
      if (state !== 4'd10 || hit_snd !== 1'b0 || score_tens !== 4'd0 || score_ones !== 4'd1) begin
         errors++;
         $display("FAIL whack_sound state=%0d hit=%0b score=%0d%0d expected state=10 hit=0 score=01",
                  state, hit_snd, score_tens, score_ones);
      end
      n = 0;
      while (state === 4'd10 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (state !== 4'd15 || n != 4) begin
         errors++;
         $display("FAIL whack_sound_len state=%0d cycles=%0d expected state=15 cycles=4", state, n);
      end
      popup_done = 1'b1;
      tick();
      checks++;
      if (state !== 4'd15) begin
         errors++;
         $display("FAIL descend_first_cycle state=%0d expected=15", state);
      end
      tick();
      popup_done = 1'b0;
      checks++;
      if (state !== 4'd2) begin
         errors++;
         $display("FAIL descend_done state=%0d expected=2", state);
      end
      $display("whack: loc=%0d score=%0d%0d state=%0d", prev_loc, score_tens, score_ones, state);
   endtask

   task automatic test_miss();
      int n;
      bit ok;
      tick();
      note_location();
      tick();
      popup_done = 1'b1;
      tick();
      checks++;
      if (state !== 4'd13) begin
         errors++;
         $display("FAIL ascend_first_cycle state=%0d expected=13", state);
      end
      tick();
      popup_done = 1'b0;
      checks++;
      if (state !== 4'd4) begin
         errors++;
         $display("FAIL miss_countdown state=%0d expected=4", state);
      end
      pad_hit = ~(8'd1 << mole_location);
      n = 0;
      while (state === 4'd4 && n < 60) begin
         tick();
         n++;
      end
      pad_hit = 8'd0;
      checks++;
      if (state !== 4'd5 || n != 50 || miss_snd !== 1'b1 || hit_snd !== 1'b0) begin
         errors++;
         $display("FAIL miss_timeout state=%0d cycles=%0d miss=%0b hit=%0b expected state=5 cycles=50 miss=1 hit=0",
                  state, n, miss_snd, hit_snd);
      end
      tick();
      checks++;
      if (state !== 4'd9 || lives !== 2'd2 || miss_snd !== 1'b0) begin
         errors++;
         $display("FAIL miss_sound state=%0d lives=%0d miss=%0b expected state=9 lives=2 miss=0", state, lives, miss_snd);
      end
      wait_for(4'd14, 10, n, ok);
      checks++;
      if (ok !== 1'b1 || n != 4) begin
         errors++;
         $display("FAIL miss_happy_desc state=%0d cycles=%0d expected state=14 cycles=4", state, n);
      end
      popup_done = 1'b1;
      wait_for(4'd2, 5, n, ok);
      popup_done = 1'b0;
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL miss_return state=%0d expected=2", state);
      end
      $display("miss: lives=%0d state=%0d", lives, state);
   endtask

   task automatic test_hit_timeout();
      int n;
      bit ok;
      tick();
      note_location();
      tick();
      popup_done = 1'b1;
      tick();
      tick();
      popup_done = 1'b0;
      repeat (49) tick();
      checks++;
      if (state !== 4'd4) begin
         errors++;
         $display("FAIL last_countdown_cycle state=%0d expected=4", state);
      end
      pad_hit = 8'd1 << mole_location;
      tick();
      pad_hit = 8'd0;
      checks++;
      if (state !== 4'd6 || lives !== 2'd2) begin
         errors++;
         $display("FAIL hit_beats_timeout state=%0d lives=%0d expected state=6 lives=2", state, lives);
      end
      wait_for(4'd15, 20, n, ok);
      popup_done = 1'b1;
      wait_for(4'd2, 5, n, ok);
      popup_done = 1'b0;
      checks++;
      if (ok !== 1'b1 || score_tens !== 4'd0 || score_ones !== 4'd2) begin
         errors++;
         $display("FAIL hit_timeout_score state=%0d score=%0d%0d expected state=2 score=02", state, score_tens, score_ones);
      end
      $display("hit+timeout: score=%0d%0d lives=%0d", score_tens, score_ones, lives);
   endtask

   task automatic test_game_over();
      int n;
      bit ok, ok_all;
      ok_all = 1'b1;
      repeat (2) begin
         miss_round(ok);
         ok_all &= ok;
      end
      checks++;
      if (ok_all !== 1'b1 || lives !== 2'd0) begin
         errors++;
         $display("FAIL two_more_misses ok=%0b lives=%0d expected ok=1 lives=0", ok_all, lives);
      end
      tick();
      repeat (3) tick();
      checks++;
      if (state !== 4'd8 || score_tens !== 4'd0 || score_ones !== 4'd2 || lives !== 2'd0) begin
         errors++;
         $display("FAIL game_over state=%0d score=%0d%0d lives=%0d expected state=8 score=02 lives=0",
                  state, score_tens, score_ones, lives);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (state !== 4'd1 || lives !== 2'd3 || score_tens !== 4'd0 || score_ones !== 4'd0) begin
         errors++;
         $display("FAIL restart state=%0d lives=%0d score=%0d%0d expected state=1 lives=3 score=00",
                  state, lives, score_tens, score_ones);
      end
      wait_for(4'd2, 20, n, ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL restart_delay state=%0d expected=2", state);
      end
      $display("game over/restart: state=%0d lives=%0d", state, lives);
   endtask

   task automatic test_score();
      bit ok, ok_all;
      ok_all = 1'b1;
      prev_loc = -1;
      loc_repeats = 0;
      repeat (9) begin whack_round(ok); ok_all &= ok; end
      checks++;
      if (score_tens !== 4'd0 || score_ones !== 4'd9) begin
         errors++;
         $display("FAIL score_09 score=%0d%0d expected=09", score_tens, score_ones);
      end
      whack_round(ok); ok_all &= ok;
      checks++;
      if (score_tens !== 4'd1 || score_ones !== 4'd0) begin
         errors++;
         $display("FAIL score_carry score=%0d%0d expected=10", score_tens, score_ones);
      end
      repeat (89) begin whack_round(ok); ok_all &= ok; end
      checks++;
      if (score_tens !== 4'd9 || score_ones !== 4'd9) begin
         errors++;
         $display("FAIL score_99 score=%0d%0d expected=99", score_tens, score_ones);
      end
      whack_round(ok); ok_all &= ok;
      checks++;
      if (score_tens !== 4'd9 || score_ones !== 4'd9) begin
         errors++;
         $display("FAIL score_saturate score=%0d%0d expected=99", score_tens, score_ones);
      end
      repeat (100) begin whack_round(ok); ok_all &= ok; end
      checks++;
      if (ok_all !== 1'b1 || lives !== 2'd3) begin
         errors++;
         $display("FAIL whack_rounds ok=%0b lives=%0d expected ok=1 lives=3", ok_all, lives);
      end
      checks++;
      if (loc_repeats != 0) begin
         errors++;
         $display("FAIL location_repeat repeats=%0d expected=0", loc_repeats);
      end
      $display("score: 200 rounds, score=%0d%0d repeats=%0d", score_tens, score_ones, loc_repeats);
   endtask

   task automatic test_reset_midround();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (state !== 4'd0 || mole_location !== 3'd0 || lives !== 2'd0 ||
          score_tens !== 4'd0 || score_ones !== 4'd0 || hit_snd !== 1'b0 || miss_snd !== 1'b0) begin
         errors++;
         $display("FAIL midround_reset state=%0d loc=%0d lives=%0d score=%0d%0d expected all zero",
                  state, mole_location, lives, score_tens, score_ones);
      end
      $display("mid-round reset: state=%0d", state);
   endtask

   initial begin
      test_reset();
      test_start_delay();
      test_whack();
      test_miss();
      test_hit_timeout();
      test_game_over();
      test_score();
      test_reset_midround();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
